// File: rtl/ultrasound_rx_pkg.sv
// Shared state encoding and default timing constants for the 90 kHz echo receiver.
package ultrasound_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    LISTEN = 2'd2
  } rx_state_t;

  // Defaults in 50 MHz cycles: 1 ms blank, 30 ms timeout, 90 kHz period window (nominal 555.6)
  localparam int BLANK_CYC_DEF   = 50000;
  localparam int TIMEOUT_CYC_DEF = 1500000;
  localparam int PER_MIN_DEF     = 500;
  localparam int PER_MAX_DEF     = 612;
  localparam int N_CONFIRM_DEF   = 4;
  localparam int TOF_W_DEF       = 21;

endpackage

// File: rtl/echo_input_conditioner.sv
// Synchronises the comparator output and emits a one-cycle strobe per rising edge.
// Defining ECHO_GLITCH_FILTER_EN adds a 3-sample majority filter (rejects pulses < 2 cycles).
module echo_input_conditioner (
  input  logic clk,
  input  logic rst,
  input  logic echo_in,
  output logic echo_edge
);

  logic sync_1;
  logic sync_2;
  logic level;
  logic level_q;
  logic edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= echo_in;
      sync_2 <= sync_1;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       maj_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= 2'b00;
      maj_q <= 1'b0;
    end else begin
      hist  <= {hist[0], sync_2};
      maj_q <= (sync_2 & hist[0]) | (sync_2 & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign level = maj_q;
`else
  assign level = sync_2;
`endif

  // Registered strobe so the timestamp taken downstream lands at n+2 (n+4 filtered)
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      level_q <= level;
      edge_q  <= level & ~level_q;
    end
  end

  assign echo_edge = edge_q;

endmodule

// File: rtl/ultrasound_echo_receiver_90khz.sv
// Blanks ring-down after each launch, qualifies a 90 kHz echo train by period and reports ToF or timeout.
// Optional ECHO_GLITCH_FILTER_EN (in echo_input_conditioner) adds two cycles of edge latency.
module ultrasound_echo_receiver_90khz
  import ultrasound_rx_pkg::*;
#(
  parameter int BLANK_CYC   = BLANK_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int PER_MIN     = PER_MIN_DEF,
  parameter int PER_MAX     = PER_MAX_DEF,
  parameter int N_CONFIRM   = N_CONFIRM_DEF,
  parameter int TOF_W       = TOF_W_DEF
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             launch_start,
  input  logic             echo_in,
  output logic             busy,
  output logic             tof_valid,
  output logic [TOF_W-1:0] tof_cycles,
  output logic             timeout
);

  localparam int PER_W  = $clog2(PER_MAX + 2);
  localparam int CONF_W = $clog2(N_CONFIRM + 1);

  localparam logic [TOF_W-1:0]  BLANK_T   = TOF_W'(BLANK_CYC);
  localparam logic [TOF_W-1:0]  TIMEOUT_T = TOF_W'(TIMEOUT_CYC);
  localparam logic [PER_W-1:0]  PER_MIN_T = PER_W'(PER_MIN);
  localparam logic [PER_W-1:0]  PER_MAX_T = PER_W'(PER_MAX);
  localparam logic [PER_W-1:0]  PER_SAT   = PER_W'(PER_MAX + 1);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(N_CONFIRM - 1);

  rx_state_t         state;
  rx_state_t         state_next;
  logic [TOF_W-1:0]  tof_cnt;
  logic [TOF_W-1:0]  stamp;
  logic [PER_W-1:0]  per_cnt;
  logic [CONF_W-1:0] confirm;
  logic              cand;
  logic              echo_edge;
  logic              in_window;
  logic              fire_valid;
  logic              fire_timeout;
  logic              cand_open;
  logic              cand_confirm;

  echo_input_conditioner u_cond (
    .clk       (clk_50M),
    .rst       (rst),
    .echo_in   (echo_in),
    .echo_edge (echo_edge)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk_50M) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A confirming edge is evaluated before the timeout so it wins on a tie
  always_comb begin
    state_next   = state;
    fire_valid   = 1'b0;
    fire_timeout = 1'b0;
    cand_open    = 1'b0;
    cand_confirm = 1'b0;
    in_window    = (per_cnt >= PER_MIN_T) && (per_cnt <= PER_MAX_T);
    case (state)
      IDLE: begin
        if (launch_start) state_next = BLANK;
      end
      BLANK: begin
        if (launch_start)            state_next = BLANK;
        else if (tof_cnt == BLANK_T) state_next = LISTEN;
      end
      LISTEN: begin
        if (launch_start) begin
          state_next = BLANK;
        end else begin
          if (echo_edge) begin
            if (cand && in_window) begin
              if (confirm == CONF_LAST) fire_valid   = 1'b1;
              else                      cand_confirm = 1'b1;
            end else begin
              cand_open = 1'b1;
            end
          end
          if (fire_valid) begin
            state_next = IDLE;
          end else if (tof_cnt >= TIMEOUT_T) begin
            fire_timeout = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst)                            tof_cnt <= '0;
    else if (launch_start)              tof_cnt <= '0;
    else if (busy && (tof_cnt != '1))   tof_cnt <= tof_cnt + TOF_W'(1);
  end

  // per_cnt holds the cycles elapsed since the candidate's latest edge
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      cand    <= 1'b0;
      stamp   <= '0;
      per_cnt <= '0;
      confirm <= '0;
    end else if (state_next != LISTEN) begin
      cand <= 1'b0;
    end else if (cand_open) begin
      cand    <= 1'b1;
      stamp   <= tof_cnt;
      per_cnt <= PER_W'(1);
      confirm <= '0;
    end else if (cand_confirm) begin
      per_cnt <= PER_W'(1);
      confirm <= confirm + CONF_W'(1);
    end else if (cand) begin
      if (per_cnt == PER_SAT) cand    <= 1'b0;
      else                    per_cnt <= per_cnt + PER_W'(1);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      tof_valid  <= 1'b0;
      timeout    <= 1'b0;
      tof_cycles <= '0;
    end else begin
      tof_valid <= fire_valid;
      timeout   <= fire_timeout;
      if (fire_valid) tof_cycles <= stamp;
    end
  end

endmodule

// File: tb/tb_ultrasound_echo_receiver_90khz.sv
// Directed bench for the echo receiver, using shortened blank/timeout so each launch stays short.
module tb_ultrasound_echo_receiver_90khz;

`ifdef ECHO_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int BLANK = 1000;
  localparam int TOUT  = 6000;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        launch_start = 1'b0;
  logic        echo_in = 1'b0;
  logic        busy;
  logic        tof_valid;
  logic        timeout;
  logic [20:0] tof_cycles;

  always #10 clk_50M = ~clk_50M;

  ultrasound_echo_receiver_90khz #(
    .BLANK_CYC   (BLANK),
    .TIMEOUT_CYC (TOUT),
    .PER_MIN     (500),
    .PER_MAX     (612),
    .N_CONFIRM   (4),
    .TOF_W       (21)
  ) dut (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .launch_start (launch_start),
    .echo_in      (echo_in),
    .busy         (busy),
    .tof_valid    (tof_valid),
    .tof_cycles   (tof_cycles),
    .timeout      (timeout)
  );

  int checks = 0;
  int passed = 0;

  int   rises[$];
  int   high_w;
  int   n_valid, n_timeout, valid_at, timeout_at, busy_fall, tof_seen;
  logic busy_at0;
  logic snap_busy, snap_valid, snap_timeout;
  int   snap_tof;

  function automatic logic echo_level(input int t);
    foreach (rises[i]) if (t >= rises[i] && t < rises[i] + high_w) return 1'b1;
    return 1'b0;
  endfunction

  // rel counts posedges since the launch was sampled; outputs are observed on negedges
  task automatic run_scenario(input int ncyc, input int relaunch_at, input int rst_at);
    logic last_busy;
    n_valid = 0; n_timeout = 0; valid_at = -1; timeout_at = -1; busy_fall = -1; tof_seen = -1;
    launch_start = 1'b1;
    echo_in = 1'b0;
    @(negedge clk_50M);
    busy_at0 = busy;
    last_busy = busy;
    for (int rel = 0; rel < ncyc; rel++) begin
      if (tof_valid === 1'b1) begin n_valid++; valid_at = rel; tof_seen = int'(tof_cycles); end
      if (timeout === 1'b1) begin n_timeout++; timeout_at = rel; end
      if (last_busy && !busy && busy_fall < 0) busy_fall = rel;
      last_busy = busy;
      if (rel == rst_at) begin
        snap_busy = busy; snap_valid = tof_valid; snap_timeout = timeout; snap_tof = int'(tof_cycles);
      end
      launch_start = (rel + 1 == relaunch_at);
      rst = (rel + 1 == rst_at);
      echo_in = echo_level(rel + 1);
      @(negedge clk_50M);
    end
    launch_start = 1'b0;
    rst = 1'b0;
    echo_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk_50M);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (tof_valid !== 1'b0) $display("[TB] FAIL reset_tof_valid: got %b want 0", tof_valid); else passed++;
    checks++; if (timeout !== 1'b0) $display("[TB] FAIL reset_timeout: got %b want 0", timeout); else passed++;
    checks++; if (tof_cycles !== 21'd0) $display("[TB] FAIL reset_tof_cycles: got %0d want 0", tof_cycles); else passed++;
    rst = 1'b0;
    @(negedge clk_50M);
  endtask

  task automatic test_detect;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b want 0", busy); else passed++;
    rises.delete(); high_w = 277;
    for (int i = 0; i < 9; i++) rises.push_back(1500 + 555 * i);
    run_scenario(1500 + 8 * 555 + 400, -1, -1);
    checks++; if (busy_at0 !== 1'b1) $display("[TB] FAIL detect_busy_rise: got %b want 1", busy_at0); else passed++;
    checks++; if (n_valid !== 1) $display("[TB] FAIL detect_count: got %0d want 1", n_valid); else passed++;
    checks++; if (tof_seen !== 1500 + LAT) $display("[TB] FAIL detect_tof: got %0d want %0d", tof_seen, 1500 + LAT); else passed++;
    checks++; if (valid_at !== 1500 + 4 * 555 + LAT + 1) $display("[TB] FAIL detect_when: got %0d want %0d", valid_at, 1500 + 4 * 555 + LAT + 1); else passed++;
    checks++; if (busy_fall !== 1500 + 4 * 555 + LAT + 1) $display("[TB] FAIL detect_busy_fall: got %0d want %0d", busy_fall, 1500 + 4 * 555 + LAT + 1); else passed++;
    checks++; if (n_timeout !== 0) $display("[TB] FAIL detect_no_timeout: got %0d want 0", n_timeout); else passed++;
    checks++; if (int'(tof_cycles) !== 1500 + LAT) $display("[TB] FAIL detect_tof_hold: got %0d want %0d", tof_cycles, 1500 + LAT); else passed++;
  endtask

  task automatic test_window_edges;
    rises.delete(); high_w = 250;
    rises.push_back(1500); rises.push_back(2000); rises.push_back(2612);
    rises.push_back(3224); rises.push_back(3724);
    run_scenario(3724 + 400, -1, -1);
    checks++; if (n_valid !== 1) $display("[TB] FAIL window_count: got %0d want 1", n_valid); else passed++;
    checks++; if (tof_seen !== 1500 + LAT) $display("[TB] FAIL window_tof: got %0d want %0d", tof_seen, 1500 + LAT); else passed++;
    checks++; if (valid_at !== 3724 + LAT + 1) $display("[TB] FAIL window_when: got %0d want %0d", valid_at, 3724 + LAT + 1); else passed++;
  endtask

  task automatic test_period_reject;
    rises.delete(); high_w = 277;
    rises.push_back(1500);
    for (int i = 0; i < 5; i++) rises.push_back(2113 + 555 * i);
    run_scenario(2113 + 4 * 555 + 400, -1, -1);
    checks++; if (n_valid !== 1) $display("[TB] FAIL long613_count: got %0d want 1", n_valid); else passed++;
    checks++; if (tof_seen !== 2113 + LAT) $display("[TB] FAIL long613_tof: got %0d want %0d", tof_seen, 2113 + LAT); else passed++;
    rises.delete();
    rises.push_back(1500);
    for (int i = 0; i < 5; i++) rises.push_back(1999 + 555 * i);
    run_scenario(1999 + 4 * 555 + 400, -1, -1);
    checks++; if (n_valid !== 1) $display("[TB] FAIL short499_count: got %0d want 1", n_valid); else passed++;
    checks++; if (tof_seen !== 1999 + LAT) $display("[TB] FAIL short499_tof: got %0d want %0d", tof_seen, 1999 + LAT); else passed++;
  endtask

  task automatic test_gap_restart;
    rises.delete(); high_w = 277;
    rises.push_back(1500); rises.push_back(2055);
    for (int i = 0; i < 5; i++) rises.push_back(2755 + 555 * i);
    run_scenario(2755 + 4 * 555 + 400, -1, -1);
    checks++; if (n_valid !== 1) $display("[TB] FAIL gap_count: got %0d want 1", n_valid); else passed++;
    checks++; if (tof_seen !== 2755 + LAT) $display("[TB] FAIL gap_tof: got %0d want %0d", tof_seen, 2755 + LAT); else passed++;
    checks++; if (valid_at !== 2755 + 4 * 555 + LAT + 1) $display("[TB] FAIL gap_when: got %0d want %0d", valid_at, 2755 + 4 * 555 + LAT + 1); else passed++;
  endtask

  task automatic test_blank_timeout;
    rises.delete(); high_w = 277;
    rises.push_back(100); rises.push_back(655);
    run_scenario(TOUT + 100, -1, -1);
    checks++; if (n_valid !== 0) $display("[TB] FAIL blank_valid: got %0d want 0", n_valid); else passed++;
    checks++; if (n_timeout !== 1) $display("[TB] FAIL blank_timeout_count: got %0d want 1", n_timeout); else passed++;
    checks++; if (timeout_at !== TOUT + 1) $display("[TB] FAIL blank_timeout_when: got %0d want %0d", timeout_at, TOUT + 1); else passed++;
    checks++; if (busy_fall !== TOUT + 1) $display("[TB] FAIL blank_busy_fall: got %0d want %0d", busy_fall, TOUT + 1); else passed++;
    checks++; if (int'(tof_cycles) !== 2755 + LAT) $display("[TB] FAIL blank_tof_hold: got %0d want %0d", tof_cycles, 2755 + LAT); else passed++;
  endtask

  task automatic test_40khz;
    rises.delete(); high_w = 625;
    for (int i = 0; i < 4; i++) rises.push_back(1500 + 1250 * i);
    run_scenario(TOUT + 100, -1, -1);
    checks++; if (n_valid !== 0) $display("[TB] FAIL slow_valid: got %0d want 0", n_valid); else passed++;
    checks++; if (n_timeout !== 1) $display("[TB] FAIL slow_timeout_count: got %0d want 1", n_timeout); else passed++;
    checks++; if (timeout_at !== TOUT + 1) $display("[TB] FAIL slow_timeout_when: got %0d want %0d", timeout_at, TOUT + 1); else passed++;
  endtask

  task automatic test_back_to_back;
    rises.delete(); high_w = 277;
    rises.push_back(2000); rises.push_back(2555);
    for (int i = 0; i < 6; i++) rises.push_back(4500 + 555 * i);
    run_scenario(7500, 3000, -1);
    checks++; if (n_valid !== 1) $display("[TB] FAIL relaunch_count: got %0d want 1", n_valid); else passed++;
    checks++; if (tof_seen !== 1500 + LAT) $display("[TB] FAIL relaunch_tof: got %0d want %0d", tof_seen, 1500 + LAT); else passed++;
    checks++; if (valid_at !== 4500 + 4 * 555 + LAT + 1) $display("[TB] FAIL relaunch_when: got %0d want %0d", valid_at, 4500 + 4 * 555 + LAT + 1); else passed++;
    checks++; if (n_timeout !== 0) $display("[TB] FAIL relaunch_timeout: got %0d want 0", n_timeout); else passed++;
    checks++; if (busy_fall !== 4500 + 4 * 555 + LAT + 1) $display("[TB] FAIL relaunch_busy_fall: got %0d want %0d", busy_fall, 4500 + 4 * 555 + LAT + 1); else passed++;
  endtask

  task automatic test_rst_mid;
    rises.delete(); high_w = 277;
    rises.push_back(1500);
    for (int i = 0; i < 5; i++) rises.push_back(3000 + 555 * i);
    run_scenario(TOUT + 100, -1, 2500);
    checks++; if (snap_busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", snap_busy); else passed++;
    checks++; if (snap_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", snap_valid); else passed++;
    checks++; if (snap_timeout !== 1'b0) $display("[TB] FAIL rst_timeout: got %b want 0", snap_timeout); else passed++;
    checks++; if (snap_tof !== 0) $display("[TB] FAIL rst_tof: got %0d want 0", snap_tof); else passed++;
    checks++; if (busy_fall !== 2500) $display("[TB] FAIL rst_busy_fall: got %0d want 2500", busy_fall); else passed++;
    checks++; if (n_valid !== 0) $display("[TB] FAIL rst_ignored_valid: got %0d want 0", n_valid); else passed++;
    checks++; if (n_timeout !== 0) $display("[TB] FAIL rst_ignored_timeout: got %0d want 0", n_timeout); else passed++;
    checks++; if (tof_cycles !== 21'd0) $display("[TB] FAIL rst_tof_end: got %0d want 0", tof_cycles); else passed++;
  endtask

  initial begin
    $display("[TB] start, edge latency %0d", LAT);
    test_reset;
    test_detect;
    test_window_edges;
    test_period_reject;
    test_gap_restart;
    test_blank_timeout;
    test_40khz;
    test_back_to_back;
    test_rst_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ultrasound_echo_receiver_90khz.md
# ultrasound_echo_receiver_90KHz

Receive-side counterpart of the 90 kHz ultrasound launcher. On each launch it blanks the transducer ring-down, then qualifies a 90 kHz echo on the comparator output `echo_in` by period, and reports time-of-flight in 50 MHz clock cycles or a timeout. It sits beside the launcher and drives the ranging/ToF logic.

## Interface
- `BLANK_CYC`, 50000: cycles after launch during which edges are ignored (1 ms).
- `TIMEOUT_CYC`, 1500000: cycles after launch at which listening gives up (30 ms).
- `PER_MIN`, 500: minimum accepted rising-edge period in cycles.
- `PER_MAX`, 612: maximum accepted period; nominal is 555.6.
- `N_CONFIRM`, 4: consecutive in-window periods required for detection.
- `TOF_W`, 21: width of the ToF counter; must hold `TIMEOUT_CYC`.
- `clk_50M`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `launch_start`  in  1  single-cycle pulse marking burst start, from the launcher.
- `echo_in`  in  1  asynchronous comparator output.
- `busy`  out  1  high in BLANK or LISTEN.
- `tof_valid`  out  1  single-cycle pulse; `tof_cycles` is valid on that cycle.
- `tof_cycles`  out  TOF_W  time-of-flight; holds its value until the next `tof_valid`.
- `timeout`  out  1  single-cycle pulse when no echo is qualified.

## Operation
- The state machine is IDLE → BLANK → LISTEN → IDLE.
- IDLE:
  - `launch_start` clears the ToF counter and goes to BLANK.
  - Conditioner edges are ignored.
- ToF counter:
  - 0 on the cycle `launch_start` is sampled; +1 every cycle while busy.
  - Saturates at all-ones.
- BLANK:
  - Edges are discarded.
  - When the counter reaches `BLANK_CYC`, go to LISTEN with no candidate.
- LISTEN, on an edge with no candidate: open a candidate, store the timestamp, clear the period counter, set confirm count to 0.
- LISTEN, on an edge with a candidate:
  - Period in [`PER_MIN`, `PER_MAX`] (inclusive): increment the confirm count.
  - Period outside the window: restart the candidate at this edge.
- Period counter:
  - Saturates at `PER_MAX`+1.
  - Reaching `PER_MAX`+1 drops the candidate.
- Confirm count reaches `N_CONFIRM`:
  - `tof_cycles` ← stored timestamp (the first edge of the train).
  - Pulse `tof_valid`; go to IDLE.
- ToF counter reaches `TIMEOUT_CYC` in LISTEN:
  - Pulse `timeout`; `tof_cycles` is unchanged; go to IDLE.
- Boundary conditions:
  - Confirming edge on the same cycle as timeout: confirm wins and `timeout` stays low.
  - `launch_start` in BLANK or LISTEN: restart. The counter clears, the candidate is dropped, the state goes to BLANK, and no pulse is emitted.
  - `rst` mid-operation: returns to IDLE; all state is cleared.

## Timing
- Reset values:
  - `busy`, `tof_valid`, `timeout` = 0.
  - `tof_cycles` = 0.
  - State = IDLE.
- `echo_in` first sampled high at cycle k: the edge is recognised at k+2 through the 2-FF synchroniser.
- Timestamp: the ToF counter value on the recognition cycle. A rising edge sampled n cycles after launch gives `tof_cycles` = n+2.
- `tof_valid` and `timeout` are registered and appear 1 cycle after the deciding event.
- `busy` rises the cycle after `launch_start` and falls with the `tof_valid`/`timeout` pulse.
- A period is the difference in recognition cycles between successive edges.

## Configuration
- `ECHO_GLITCH_FILTER_EN` defined:
  - Adds a 3-sample majority filter after the synchroniser.
  - Edge recognition moves to k+4, so `tof_cycles` = n+4.
  - Pulses shorter than 2 cycles are rejected.
- Undefined: synchroniser plus edge detect only, with the latency given in Timing.

## Structure
- Package `ultrasound_rx_pkg` holds:
  - The state enum (IDLE, BLANK, LISTEN).
  - Default constants for the 90 kHz period window, the blank time and the timeout.
- Sub-module `echo_input_conditioner` holds the 2-FF synchroniser, the optional majority filter and the rising-edge detect. It outputs a single-cycle `edge` strobe.

## Test plan
- Launch, then a 90 kHz square (555-cycle period, 277 high) starting 100000 cycles after the launch sample, 8 periods → `tof_valid` once, `tof_cycles` = 100002 (100004 with filter); `busy` falls the same cycle.
- Echo burst only at 25000 cycles (inside blank), nothing after → no `tof_valid`; `timeout` pulse 1 cycle after the counter hits 1500000.
- 40 kHz echo (1250-cycle period) at 200000 → no detection, `timeout` at 1500000.
- 90 kHz train at 300000 with one 700-cycle period after the 2nd edge → candidate restarts; `tof_cycles` = recognition timestamp of the edge that ends the 700-cycle gap.
- Second `launch_start` at 600000 during LISTEN, echo 100000 cycles later → `tof_cycles` = 100002, and no `timeout` for the first launch.
- `rst` asserted for 1 cycle mid-LISTEN → all outputs 0, state IDLE, and following echo edges are ignored until the next `launch_start`.
